integ_window_ctrl: RTL and testbench
====================================

# integ_window_ctrl

Windowed integrate-and-dump controller for the sample integration path. Accepts a stream of signed samples, sums exactly `win_len` accepted samples per window, and presents each window sum on a valid/ready output. Supports single-shot and continuous operation. Sits between the ADC sample stream and downstream consumers, replacing free-running accumulation with deterministic window sequencing and back-pressure.

## Interface
- `SAMPLE_W`, 16: input sample width, signed
- `ACC_W`, 32: accumulator and result width, signed; `ACC_W >= SAMPLE_W + LEN_W`
- `LEN_W`, 16: window-length width

- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: one-cycle command; begins a window when IDLE
- `stop` in 1: one-cycle command; ends operation
- `continuous` in 1: sampled with `start`; 1 = re-arm after each result
- `win_len` in LEN_W: samples per window, sampled with `start`; 0 treated as 1
- `in_valid` in 1: sample valid
- `in_ready` out 1: sample accepted when `in_valid && in_ready`
- `in_data` in SAMPLE_W: signed sample
- `out_valid` out 1: result valid
- `out_ready` in 1: downstream accepts result
- `out_data` out ACC_W: signed window sum
- `out_ovf` out 1: result saturated (see Configuration)
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: `in_ready`=0. `start` && !`stop` -> RUN; latch `win_len` (0->1) and `continuous`; clear accumulator and sample counter.
- RUN: `in_ready`=1. Each accepted sample: acc += sign-extended `in_data`, count++. On accepting sample number L: register acc+sample into `out_data`, set `out_valid`, -> HOLD.
- HOLD: `in_ready`=0; `out_data`/`out_ovf` stable while `out_valid` && !`out_ready`. On handshake: clear `out_valid`; if latched continuous and no stop pending -> RUN with acc/count cleared, else -> IDLE.
- `stop` in RUN: abort, partial sum discarded, no result, -> IDLE next cycle; a sample accepted in that same cycle is discarded.
- `stop` in HOLD: set stop_pending; pending result still delivered, then IDLE.
- `start` outside IDLE ignored; `start`+`stop` same cycle in IDLE: stay IDLE.
- `win_len`/`continuous` changes outside IDLE have no effect until next `start`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ovf`=0, `in_ready`=0, `busy`=0; state IDLE; stop_pending=0.
- `start` at cycle n -> `in_ready`=1 at n+1.
- Last sample accepted at cycle m -> `out_valid`=1 at m+1, `in_ready`=0 at m+1.
- Handshake at cycle k in continuous mode -> `in_ready`=1 at k+1 (one bubble cycle per window).
- Reset mid-operation: all state cleared next edge; in-flight result lost.

## Configuration
- `INTEG_CTRL_SAT_EN` defined: each add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; once saturated in a window, `out_ovf`=1 with that window's result; cleared at next window start.
- Not defined: two's-complement wrap; `out_ovf` tied 0.

## Structure
- Package `integ_pkg`: state enum typedef (IDLE/RUN/HOLD), ACC_MAX/ACC_MIN constants derived from ACC_W.
- Sub-module `integ_acc`: accumulator register with clear, add-enable, optional saturation and sticky overflow; controller owns FSM, counter, output register.

## Test plan
- Single-shot: `win_len`=4, samples 1,2,3,4, `out_ready`=1 -> one result 10, `out_valid` 1 cycle after 4th sample, then IDLE, `busy`=0.
- Continuous with back-pressure: `win_len`=3, samples 1..9, `out_ready` low 5 cycles per result -> results 6,15,24 in order; `in_ready`=0 throughout each HOLD; no samples lost.
- Negative/zero-length: `win_len`=0, samples -5,7 -> results -5 then 7 (continuous), each window one sample.
- Stop cases: `stop` after 2 of 4 samples -> no result, IDLE; `stop` during HOLD -> held result delivered, then IDLE.
- Saturation (`INTEG_CTRL_SAT_EN`, ACC_W=20, SAMPLE_W=16): `win_len`=40, all samples 32767 -> `out_data`=524287, `out_ovf`=1; without macro -> wrapped value, `out_ovf`=0.
- Reset in RUN after 2 samples -> all outputs at reset values next cycle; fresh `start` produces correct sum.

Source files
------------

// File: rtl/integ_pkg.sv
// Shared types and width-derived saturation bounds for the integrate-and-dump controller.
package integ_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Bounds for a w-bit signed accumulator; callers truncate to w bits.
  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

endpackage

// File: rtl/integ_acc.sv
// Window accumulator with clear/add-enable; saturating with sticky overflow when
// INTEG_CTRL_SAT_EN is defined, plain two's-complement wrap otherwise.
module integ_acc
  import integ_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                add_en,
  input  logic [SAMPLE_W-1:0] din,
  output logic [ACC_W-1:0]    sum_nxt,
  output logic                ovf_nxt
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] din_ext;

  assign din_ext = {{(ACC_W - SAMPLE_W){din[SAMPLE_W-1]}}, din};

`ifdef INTEG_CTRL_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] wide;
  logic           sat_now;
  logic           ovf_q, ovf_d;

  // One guard bit: sign and guard disagree exactly when the add overflowed.
  assign wide    = {acc_q[ACC_W-1], acc_q} + {din_ext[ACC_W-1], din_ext};
  assign sat_now = wide[ACC_W] ^ wide[ACC_W-1];
  assign sum_nxt = sat_now ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];
  assign ovf_nxt = ovf_q | sat_now;

  always_comb begin
    ovf_d = ovf_q;
    if (clr)         ovf_d = 1'b0;
    else if (add_en) ovf_d = ovf_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`else
  assign sum_nxt = acc_q + din_ext;
  assign ovf_nxt = 1'b0;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (add_en) acc_d = sum_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/integ_window_ctrl.sv
// Windowed integrate-and-dump controller: sums win_len samples per window and hands each
// sum out on valid/ready. Saturation is enabled by defining INTEG_CTRL_SAT_EN.
module integ_window_ctrl
  import integ_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [LEN_W-1:0]    win_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_ovf,
  output logic                busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             cont_q, cont_d;
  logic             stop_pend_q, stop_pend_d;
  logic             out_valid_q, out_valid_d;
  logic             out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             acc_clr, acc_add, acc_ovf;
  logic [ACC_W-1:0] acc_sum;

  integ_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .add_en (acc_add),
    .din    (in_data),
    .sum_nxt(acc_sum),
    .ovf_nxt(acc_ovf)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    out_data_d  = out_data_q;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d = RUN;
          len_d   = (win_len == '0) ? LEN_W'(1) : win_len;
          cont_d  = continuous;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      end
      RUN: begin
        // A stop wins over a sample offered in the same cycle: the sample is dropped.
        if (stop) begin
          state_d = IDLE;
        end else if (in_valid) begin
          acc_add = 1'b1;
          if (cnt_q == len_q - LEN_W'(1)) begin
            out_data_d  = acc_sum;
            out_ovf_d   = acc_ovf;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      HOLD: begin
        if (stop) stop_pend_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cont_q && !stop_pend_q && !stop) begin
            state_d = RUN;
            cnt_d   = '0;
            acc_clr = 1'b1;
          end else begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_integ_window_ctrl.sv
// Scoreboard bench for integ_window_ctrl: directed windows push expected sums, a monitor
// pops and compares on every output handshake.
module tb_integ_window_ctrl;

  localparam int SW = 16;
  localparam int AW = 20;
  localparam int LW = 8;

  typedef struct packed {
    logic [AW-1:0] d;
    logic          o;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, stop, continuous, in_valid, out_ready;
  logic [LW-1:0] win_len;
  logic [SW-1:0] in_data;
  logic          in_ready, out_valid, out_ovf, busy;
  logic [AW-1:0] out_data;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   bp_len = 0;
  int   bp_cnt = 0;

  integ_window_ctrl #(.SAMPLE_W(SW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .win_len(win_len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] d, input logic o);
    exp_t e;
    e.d = d;
    e.o = o;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [LW-1:0] len, input logic cont);
    win_len    = len;
    continuous = cont;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    chk("start_in_ready", 32'(in_ready), 1);
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic send(input logic [SW-1:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d results outstanding, required 0", nm, sb.size());
    end
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Back-pressure: hold out_ready low for bp_len cycles of each result.
  initial begin
    out_ready = 1'b1;
    forever begin
      tick();
      if (out_valid && bp_cnt < bp_len) begin
        out_ready = 1'b0;
        bp_cnt++;
      end else begin
        out_ready = 1'b1;
        if (!out_valid) bp_cnt = 0;
      end
    end
  end

  // Monitor: compares results at the handshake and checks HOLD behaviour.
  initial begin
    logic          prev_stall;
    logic [AW-1:0] prev_d;
    exp_t          e;
    prev_stall = 1'b0;
    prev_d     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid) chk("hold_in_ready", 32'(in_ready), 0);
        if (prev_stall && out_valid) chk("stall_stable", 32'(out_data), 32'(prev_d));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0d with no result expected", out_data);
          end else begin
            e = sb.pop_front();
            chk("result_data", 32'(out_data), 32'(e.d));
            chk("result_ovf", 32'(out_ovf), 32'(e.o));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    win_len = '0; in_valid = 1'b0; in_data = '0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    rst = 1'b0;
    tick();

    // Single-shot 1+2+3+4
    push(20'd10, 1'b0);
    do_start(8'd4, 1'b0);
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    chk("single_valid_m1", 32'(out_valid), 1);
    chk("single_in_ready_m1", 32'(in_ready), 0);
    tick();
    chk("single_idle", 32'(busy), 0);
    wait_empty("single_drain");

    // Continuous, 5-cycle back-pressure per result
    bp_len = 5;
    push(20'd6, 1'b0); push(20'd15, 1'b0); push(20'd24, 1'b0);
    do_start(8'd3, 1'b1);
    for (int i = 1; i <= 9; i++) send(16'(i));
    wait_empty("cont_drain");
    chk("cont_rearm_in_ready", 32'(in_ready), 1);
    pulse_stop();
    chk("cont_stop_idle", 32'(busy), 0);
    bp_len = 0;

    // Zero length behaves as one sample per window
    push(20'hFFFFB, 1'b0); push(20'd7, 1'b0);
    do_start(8'd0, 1'b1);
    send(16'hFFFB); send(16'd7);
    wait_empty("zero_len_drain");
    chk("zero_len_rearm", 32'(in_ready), 1);
    pulse_stop();
    chk("zero_len_idle", 32'(busy), 0);

    // Abort after two of four; sample offered with stop is dropped
    do_start(8'd4, 1'b0);
    send(16'd100); send(16'd200);
    in_valid = 1'b1; in_data = 16'd300; stop = 1'b1;
    tick();
    stop = 1'b0; in_valid = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    tick(); tick();
    chk("abort_no_result", 32'(out_valid), 0);
    push(20'd5, 1'b0);
    do_start(8'd2, 1'b0);
    send(16'd2); send(16'd3);
    wait_empty("after_abort_drain");

    // Stop while holding a result in continuous mode
    bp_len = 1000;
    push(20'd7, 1'b0);
    do_start(8'd2, 1'b1);
    send(16'd3); send(16'd4);
    tick();
    pulse_stop();
    tick();
    chk("stop_hold_valid", 32'(out_valid), 1);
    bp_len = 0;
    wait_empty("stop_hold_drain");
    chk("stop_hold_idle", 32'(busy), 0);

    // Reset in RUN, then a fresh window
    do_start(8'd4, 1'b0);
    send(16'd9); send(16'd9);
    rst = 1'b1;
    tick();
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    chk("mid_rst_out_ovf", 32'(out_ovf), 0);
    rst = 1'b0;
    tick();
    push(20'd3, 1'b0);
    do_start(8'd3, 1'b0);
    send(16'd1); send(16'd1); send(16'd1);
    wait_empty("after_rst_drain");

    // 40 x 32767 = 1310680 overflows a 20-bit accumulator
`ifdef INTEG_CTRL_SAT_EN
    push(20'd524287, 1'b1);
`else
    push(20'd262104, 1'b0);
`endif
    do_start(8'd40, 1'b0);
    for (int i = 0; i < 40; i++) send(16'd32767);
    wait_empty("sat_drain");

    // Fresh window after a saturated one starts with overflow clear
    push(20'hFFFFE, 1'b0);
    do_start(8'd2, 1'b0);
    send(16'hFFFF); send(16'hFFFF);
    wait_empty("post_sat_drain");

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
